// File: rtl/temp_filter.sv
// Four-sample moving-average temperature filter with registered, rounded output.
// Optional spike rejection is compiled in with the SPIKE_REJECT_EN macro.
module temp_filter #(
    parameter int SPIKE_THRESH = 4,
    parameter int SPIKE_LIMIT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [4:0] sample,
    output logic [4:0] temperature,
    output logic       temp_valid,
    output logic [1:0] spike_count
);

    // Parameters must fit the 5-bit sample range and the 2-bit spike counter.
    if (SPIKE_THRESH < 0 || SPIKE_THRESH > 31) begin : g_bad_thresh
        $error("temp_filter: SPIKE_THRESH out of range");
    end
    if (SPIKE_LIMIT < 0 || SPIKE_LIMIT > 3) begin : g_bad_limit
        $error("temp_filter: SPIKE_LIMIT out of range");
    end

    logic [3:0][4:0] window;
    logic [6:0]      sum;
    logic [2:0]      fill;
    logic [6:0]      sum_next;
    logic [2:0]      fill_next;
    logic            accept;

    function automatic logic [4:0] round_avg(input logic [6:0] total);
        // total <= 124, so total + 2 still fits in 7 bits
        return 5'((total + 7'd2) >> 2);
    endfunction

    // window[3] is the oldest entry; it reads 0 until four samples have arrived
    assign sum_next  = sum + {2'b00, sample} - {2'b00, window[3]};
    assign fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;

`ifdef SPIKE_REJECT_EN
    localparam logic [5:0] THRESH = 6'(SPIKE_THRESH);
    localparam logic [1:0] LIMIT  = 2'(SPIKE_LIMIT);

    logic signed [5:0] diff;
    logic              spike;

    function automatic logic [5:0] abs_diff(input logic signed [5:0] d);
        return (d < 0) ? 6'(-d) : 6'(d);
    endfunction

    assign diff   = $signed({1'b0, sample}) - $signed({1'b0, temperature});
    assign spike  = temp_valid && (abs_diff(diff) > THRESH);
    assign accept = sample_valid && (!spike || (spike_count == LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count <= 2'd0;
        end else if (sample_valid) begin
            if (spike && (spike_count != LIMIT)) begin
                spike_count <= spike_count + 2'd1;
            end else begin
                spike_count <= 2'd0;
            end
        end
    end
`else
    assign accept      = sample_valid;
    assign spike_count = 2'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window      <= '0;
            sum         <= 7'd0;
            fill        <= 3'd0;
            temperature <= 5'd0;
            temp_valid  <= 1'b0;
        end else if (accept) begin
            window      <= {window[2:0], sample};
            sum         <= sum_next;
            fill        <= fill_next;
            temperature <= round_avg(sum_next);
            temp_valid  <= temp_valid | (fill_next == 3'd4);
        end
    end

endmodule

// File: tb/tb_temp_filter.sv
// Self-checking bench for temp_filter: directed scenarios plus randomized samples
// checked against a queue-based moving-average reference model.
module tb_temp_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_valid = 1'b0;
    logic [4:0] sample = 5'd0;
    logic [4:0] temperature;
    logic       temp_valid;
    logic [1:0] spike_count;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int q[$];
    int m_temp = 0;
    bit m_valid = 1'b0;
    int m_spk = 0;

    temp_filter #(.SPIKE_THRESH(4), .SPIKE_LIMIT(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .sample(sample),
        .temperature(temperature),
        .temp_valid(temp_valid),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".temperature"}, 32'(temperature), 32'(m_temp));
        chk({tag, ".temp_valid"}, 32'(temp_valid), 32'(m_valid));
        chk({tag, ".spike_count"}, 32'(spike_count), 32'(m_spk));
    endtask

    function automatic void model_reset();
        q.delete();
        m_temp  = 0;
        m_valid = 1'b0;
        m_spk   = 0;
    endfunction

    // Average of the last four accepted samples (missing ones count as 0), rounded half up.
    function automatic void model_sample(input int s);
        bit spike;
        int total;
        int diff;
        spike = 1'b0;
        diff  = (s > m_temp) ? s - m_temp : m_temp - s;
`ifdef SPIKE_REJECT_EN
        if (m_valid && diff > 4) spike = 1'b1;
`endif
        if (spike && m_spk != 3) begin
            m_spk = m_spk + 1;
        end else begin
            q.push_back(s);
            m_spk = 0;
            total = 0;
            for (int i = 0; i < 4 && i < q.size(); i++) total += q[q.size() - 1 - i];
            m_temp = (total + 2) / 4;
            if (q.size() >= 4) m_valid = 1'b1;
        end
        if (diff < 0) m_spk = m_spk; // diff is a magnitude; never negative
    endfunction

    // Drive one cycle of input at the falling edge, then check just after the rising edge.
    task automatic step(input bit v, input int s, input string tag);
        @(negedge clk);
        sample_valid = v;
        sample       = 5'(s);
        @(posedge clk);
        if (v) model_sample(s);
        #1;
        chk_all(tag);
    endtask

    // Assert reset between edges, check the immediate clear, release just after a rising edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int s;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("reset_state");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // four identical samples: valid on the fourth edge
        for (int i = 0; i < 4; i++) step(1'b1, 16, "prime16");
        chk("prime16.value", 32'(temperature), 32'd16);
        chk("prime16.valid", 32'(temp_valid), 32'd1);
        step(1'b1, 20, "step20");
        chk("step20.value", 32'(temperature), 32'd17);

        // full-scale samples must not wrap, then ramp down
        for (int i = 0; i < 4; i++) step(1'b1, 31, "max31");
`ifndef SPIKE_REJECT_EN
        chk("max31.value", 32'(temperature), 32'd31);
        step(1'b1, 0, "down0a");
        chk("down0a.value", 32'(temperature), 32'd23);
        step(1'b1, 0, "down0b");
        chk("down0b.value", 32'(temperature), 32'd16);
        step(1'b1, 0, "down0c");
        chk("down0c.value", 32'(temperature), 32'd8);
        step(1'b1, 0, "down0d");
        chk("down0d.value", 32'(temperature), 32'd0);
`endif

        // hold with sample_valid low
        pulse_reset("reset_before_hold");
        for (int i = 0; i < 4; i++) step(1'b1, 18, "prime18");
        for (int i = 0; i < 20; i++) step(1'b0, 5'(i * 7), "idle");
        chk("idle.value", 32'(temperature), 32'd18);

        // spike scenario from a level of 18
`ifdef SPIKE_REJECT_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 30, "spike_drop");
            chk("spike_drop.count", 32'(spike_count), 32'(i + 1));
            chk("spike_drop.value", 32'(temperature), 32'd18);
        end
        step(1'b1, 30, "spike_accept");
        chk("spike_accept.value", 32'(temperature), 32'd21);
        chk("spike_accept.count", 32'(spike_count), 32'd0);
`else
        step(1'b1, 30, "nospike30");
        chk("nospike30.value", 32'(temperature), 32'd21);
`endif

        // mid-fill reset discards history
        pulse_reset("reset_pre_fill");
        for (int i = 0; i < 3; i++) step(1'b1, 10 + i, "partial");
        pulse_reset("reset_mid_fill");
        for (int i = 0; i < 3; i++) step(1'b1, 25, "refill");
        chk("refill.not_valid", 32'(temp_valid), 32'd0);
        step(1'b1, 25, "refill4");
        chk("refill4.valid", 32'(temp_valid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) s = int'($urandom_range(0, 31));
            else s = m_temp + int'($urandom_range(0, 6)) - 3;
            if (s < 0) s = 0;
            if (s > 31) s = 31;
            if (i == 200) pulse_reset("reset_random");
            step($urandom_range(0, 9) < 7, s, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/temp_filter.md
TEMP_FILTER -- requirements
Module: temp_filter

Interface
REQ-001 SHALL have parameter SPIKE_THRESH, default 4: maximum accepted |sample - temperature| before a sample counts as a spike.
REQ-002 SHALL have parameter SPIKE_LIMIT, default 3: number of consecutive spikes after which the next spike is accepted.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sample_valid, input, 1 bit: raw sensor sample present this cycle.
REQ-006 SHALL have port sample, input, 5 bits: raw unsigned temperature, 0-31.
REQ-007 SHALL have port temperature, output, 5 bits: filtered temperature, registered, for the downstream AC stage.
REQ-008 SHALL have port temp_valid, output, 1 bit: high once the 4-entry window is fully primed.
REQ-009 SHALL have port spike_count, output, 2 bits: current consecutive-spike count; always 0 when SPIKE_REJECT_EN is undefined.

Function
REQ-010 SHALL hold a 4-entry sample window, a 7-bit running sum and a 3-bit fill count (0-4, saturating).
REQ-011 On an accepted sample, SHALL shift it into the window, evicting the oldest entry, and set sum_next = sum + sample - evicted.
REQ-012 Before the window is full, evicted entries SHALL read as 0, so the sum equals the total of the accepted samples.
REQ-013 Fill count SHALL increment on each accepted sample until it reaches 4, then hold at 4.
REQ-014 temperature SHALL be registered as (sum_next + 2) >> 2 in the same edge that accepts the sample: 1-cycle latency from sample_valid to updated output.
REQ-015 Rounding SHALL never overflow: the maximum is (124 + 2) >> 2 = 31.
REQ-016 temp_valid SHALL rise on the edge on which the fill count reaches 4 and stay high until reset.
REQ-017 While temp_valid is 0, temperature SHALL still update per REQ-014 but is advisory only.
REQ-018 With sample_valid low, window, sum, temperature, temp_valid and spike_count SHALL all hold their values.
REQ-019 Back-to-back sample_valid cycles SHALL each be accepted; no backpressure, no dead cycles.

Reset
REQ-020 Assertion of rst_n low SHALL immediately clear window, sum, fill count, spike_count, temperature (5'd0) and temp_valid (0), regardless of clock.
REQ-021 Reset mid-operation SHALL discard all history; after release, 4 new accepted samples SHALL be needed before temp_valid rises.
REQ-022 The first rising clk edge with rst_n high SHALL already be able to accept a sample.

Configuration
REQ-023 Macro SPIKE_REJECT_EN SHALL compile in spike rejection; when it is undefined, every valid sample is accepted and spike_count is tied to 0.
REQ-024 With SPIKE_REJECT_EN defined and temp_valid = 1, a sample with |sample - temperature| > SPIKE_THRESH SHALL be a spike.
REQ-025 A spike SHALL be dropped (window, sum and temperature unchanged) and SHALL increment spike_count, unless spike_count already equals SPIKE_LIMIT.
REQ-026 If spike_count equals SPIKE_LIMIT, the spike SHALL be accepted and spike_count cleared.
REQ-027 Any non-spike accepted sample SHALL clear spike_count.
REQ-028 Spike checking SHALL be disabled while temp_valid = 0.

Verification
REQ-029 Scenario: reset, then samples 16,16,16,16 on consecutive cycles -> temp_valid rises on the 4th edge; temperature = 16.
REQ-030 Scenario: primed at 16, then sample 20 -> temperature = (68 + 2) >> 2 = 17 one cycle later.
REQ-031 Scenario: samples 31 x4 -> temperature = 31 with no wrap; then samples 0 x4 -> temperature steps 23, 16, 8, 0.
REQ-032 Scenario: primed at 18, sample_valid low for 20 cycles -> all outputs constant.
REQ-033 Scenario: after 3 of 4 samples, rst_n pulsed low between clock edges -> outputs 0 immediately; 4 fresh samples are needed for temp_valid.
REQ-034 Scenario (SPIKE_REJECT_EN): primed at 18, samples 30,30,30 -> dropped, spike_count 1,2,3; 4th sample of 30 -> accepted, temperature = 21, spike_count = 0. Without the macro, the first 30 gives temperature = 21.
